// File: rtl/spike_generator.sv
// Threshold-and-fire stage: compares an IEEE-754 potential against a programmable
// threshold, tracks per-neuron refractory counters and a per-timestep spike vector.
module spike_generator #(
    parameter int          N_NEURONS   = 10,
    parameter int          ADDR_W      = 4,
    parameter int          REFRAC_W    = 4,
    parameter logic [31:0] THRESH_INIT = 32'h40A00000,
    parameter logic [31:0] VRESET_INIT = 32'h00000000,
    parameter int          REFRAC_INIT = 2
) (
    input  logic                 CLK_Spike,
    input  logic                 RSTN_Spike,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    in_neuron,
    input  logic [31:0]          in_potential,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_W-1:0]    out_neuron,
    output logic [31:0]          out_potential,
    output logic                 out_spike,
    input  logic                 timestep_end,
    output logic [N_NEURONS-1:0] spike_vector,
    input  logic                 cfg_we,
    input  logic [31:0]          cfg_threshold,
    input  logic [31:0]          cfg_vreset,
    input  logic [REFRAC_W-1:0]  cfg_refrac,
    output logic                 err
);

    localparam logic [ADDR_W:0] N_EXT = (ADDR_W+1)'(N_NEURONS);

    logic [31:0]                        threshold_q, threshold_d;
    logic [31:0]                        vreset_q, vreset_d;
    logic [REFRAC_W-1:0]                refrac_q, refrac_d;
    logic [N_NEURONS-1:0][REFRAC_W-1:0] refrac_cnt_q, refrac_cnt_d;
    logic [N_NEURONS-1:0]               pending_q, pending_d;
    logic [N_NEURONS-1:0]               spike_vector_q, spike_vector_d;
    logic                               err_q, err_d;
    logic                               out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]                  out_neuron_q, out_neuron_d;
    logic [31:0]                        out_potential_q, out_potential_d;
    logic                               out_spike_q, out_spike_d;

    logic                 accept;
    logic                 is_nan;
    logic                 in_range;
    logic [REFRAC_W-1:0]  cur_cnt;
    logic                 fire;
    logic [N_NEURONS-1:0] fire_vec;

    // IEEE-754 a >= b for non-NaN operands, with +0 == -0.
    function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
        logic res;
        if (a[30:0] == '0 && b[30:0] == '0)
            res = 1'b1;
        else if (!a[31] && !b[31])
            res = a[30:0] >= b[30:0];
        else if (a[31] && b[31])
            res = a[30:0] <= b[30:0];
        else
            res = !a[31];
        return res;
    endfunction

    assign in_ready      = !out_valid_q || out_ready;
    assign out_valid     = out_valid_q;
    assign out_neuron    = out_neuron_q;
    assign out_potential = out_potential_q;
    assign out_spike     = out_spike_q;
    assign spike_vector  = spike_vector_q;
    assign err           = err_q;

    always_comb begin
        accept   = in_valid && in_ready;
        is_nan   = (&in_potential[30:23]) && (|in_potential[22:0]);
        in_range = {1'b0, in_neuron} < N_EXT;

        cur_cnt = '0;
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            if (ADDR_W'(i) == in_neuron)
                cur_cnt = refrac_cnt_q[i];
        end

        fire = accept && in_range && !is_nan && (cur_cnt == '0)
               && fp_ge(in_potential, threshold_q);

        fire_vec = '0;
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            fire_vec[i] = fire && (ADDR_W'(i) == in_neuron);
        end
    end

    always_comb begin
        threshold_d     = threshold_q;
        vreset_d        = vreset_q;
        refrac_d        = refrac_q;
        refrac_cnt_d    = refrac_cnt_q;
        pending_d       = pending_q | fire_vec;
        spike_vector_d  = spike_vector_q;
        err_d           = err_q;
        out_valid_d     = out_valid_q;
        out_neuron_d    = out_neuron_q;
        out_potential_d = out_potential_q;
        out_spike_d     = out_spike_q;

        if (accept) begin
            out_valid_d  = 1'b1;
            out_neuron_d = in_neuron;
            out_spike_d  = fire;
            if (!in_range)
                out_potential_d = in_potential;
            else if (is_nan || fire || cur_cnt != '0)
                out_potential_d = vreset_q;
            else
                out_potential_d = in_potential;
            if (is_nan || !in_range)
                err_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A fire in the same cycle as timestep_end reloads its counter after the decrement.
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            if (fire_vec[i])
                refrac_cnt_d[i] = refrac_q;
            else if (timestep_end && refrac_cnt_q[i] != '0)
                refrac_cnt_d[i] = refrac_cnt_q[i] - REFRAC_W'(1);
        end

        if (timestep_end) begin
            spike_vector_d = pending_q | fire_vec;
            pending_d      = '0;
        end

        if (cfg_we) begin
            threshold_d = cfg_threshold;
            vreset_d    = cfg_vreset;
            refrac_d    = cfg_refrac;
        end
    end

    always_ff @(posedge CLK_Spike or negedge RSTN_Spike) begin
        if (!RSTN_Spike) begin
            threshold_q     <= THRESH_INIT;
            vreset_q        <= VRESET_INIT;
            refrac_q        <= REFRAC_W'(REFRAC_INIT);
            refrac_cnt_q    <= '0;
            pending_q       <= '0;
            spike_vector_q  <= '0;
            err_q           <= 1'b0;
            out_valid_q     <= 1'b0;
            out_neuron_q    <= '0;
            out_potential_q <= '0;
            out_spike_q     <= 1'b0;
        end else begin
            threshold_q     <= threshold_d;
            vreset_q        <= vreset_d;
            refrac_q        <= refrac_d;
            refrac_cnt_q    <= refrac_cnt_d;
            pending_q       <= pending_d;
            spike_vector_q  <= spike_vector_d;
            err_q           <= err_d;
            out_valid_q     <= out_valid_d;
            out_neuron_q    <= out_neuron_d;
            out_potential_q <= out_potential_d;
            out_spike_q     <= out_spike_d;
        end
    end

endmodule
